// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings, default geometry and the even-parity helper.
// Used by both the receiver and the transmitter so encodings and parity rules cannot drift.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam int DEF_DATA_BITS  = 8;
    localparam int DEF_OVERSAMPLE = 16;

    // Even parity bit for up to 32 data bits; callers zero-extend narrower words.
    function automatic logic even_parity(input logic [31:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// RESET_VAL sets both flops on reset (1 for an idle-high UART line).
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receiver: 16x oversampled, mid-bit sampling, start + DATA_BITS (LSB first) + stop.
// Build option UART_RX_PARITY_EN adds an even parity bit between data and stop.
//   state  | meaning
//   IDLE   | line idle, waiting for a low sample on a baud tick
//   START  | counting to mid start bit, rejecting glitches
//   DATA   | sampling one data bit per bit period
//   PARITY | sampling the parity bit (parity build only)
//   STOP   | sampling the stop bit, latching outputs, strobing rx_valid
module uart_rx_fsm
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_busy,
    output logic                 parity_err,
    output logic                 frame_err
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    uart_state_t          state;
    logic [TW-1:0]        tcnt;
    logic [BW-1:0]        bcnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 rx_s;
`ifdef UART_RX_PARITY_EN
    logic                 perr_q;
`endif

    uart_sync2 #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            tcnt       <= '0;
            bcnt       <= '0;
            shreg      <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_busy    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q     <= 1'b0;
`endif
        end else begin
            rx_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (baud_tick && !rx_s) begin
                        state   <= ST_START;
                        tcnt    <= '0;
                        bcnt    <= '0;
                        rx_busy <= 1'b1;
                    end
                end

                ST_START: begin
                    if (baud_tick) begin
                        if (tcnt == T_MID) begin
                            tcnt <= '0;
                            if (!rx_s) begin
                                state <= ST_DATA;
                            end else begin
                                state   <= ST_IDLE;
                                rx_busy <= 1'b0;
                            end
                        end else begin
                            tcnt <= tcnt + TW'(1);
                        end
                    end
                end

                ST_DATA: begin
                    if (baud_tick) begin
                        if (tcnt == T_LAST) begin
                            tcnt  <= '0;
                            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                            if (bcnt == B_LAST) begin
                                bcnt  <= '0;
`ifdef UART_RX_PARITY_EN
                                state <= ST_PARITY;
`else
                                state <= ST_STOP;
`endif
                            end else begin
                                bcnt <= bcnt + BW'(1);
                            end
                        end else begin
                            tcnt <= tcnt + TW'(1);
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (baud_tick) begin
                        if (tcnt == T_LAST) begin
                            tcnt   <= '0;
                            perr_q <= even_parity(32'(shreg)) ^ rx_s;
                            state  <= ST_STOP;
                        end else begin
                            tcnt <= tcnt + TW'(1);
                        end
                    end
                end
`endif

                // Leave at mid stop bit so a start edge right after the stop bit is not missed.
                ST_STOP: begin
                    if (baud_tick) begin
                        if (tcnt == T_LAST) begin
                            tcnt      <= '0;
                            rx_data   <= shreg;
                            frame_err <= ~rx_s;
`ifdef UART_RX_PARITY_EN
                            parity_err <= perr_q;
`else
                            parity_err <= 1'b0;
`endif
                            rx_valid  <= 1'b1;
                            rx_busy   <= 1'b0;
                            state     <= ST_IDLE;
                        end else begin
                            tcnt <= tcnt + TW'(1);
                        end
                    end
                end

                default: begin
                    state   <= ST_IDLE;
                    tcnt    <= '0;
                    bcnt    <= '0;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: drives framed serial bytes aligned to baud ticks and checks each
// received byte, its error flags and its start-edge-to-strobe latency against a frame model.
`timescale 1ns/1ps
module tb_uart_rx_fsm;

    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;
    localparam int TICK_CLKS  = 4;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    // Edge lands just after a tick; sync delay is absorbed by the next tick, which detects the
    // start; then half a bit to mid-start and one full bit per data/parity/stop bit.
    localparam int LAT = TICK_CLKS * (1 + OVERSAMPLE / 2 + OVERSAMPLE * (DATA_BITS + PAR_BITS + 1));

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       baud_tick;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       parity_err;
    logic       frame_err;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   div      = 0;
    exp_t exp_q[$];

    uart_rx_fsm #(
        .DATA_BITS  (DATA_BITS),
        .OVERSAMPLE (OVERSAMPLE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .baud_tick  (baud_tick),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_busy    (rx_busy),
        .parity_err (parity_err),
        .frame_err  (frame_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        baud_tick = 1'b0;
        forever begin
            @(negedge clk);
            baud_tick = (div == 0);
            div = (div + 1) % TICK_CLKS;
        end
    end

    // Strobe monitor: every rx_valid must match the oldest outstanding frame.
    initial begin
        logic prev_valid;
        exp_t e;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rx_valid) begin
                check("valid_width", 32'(prev_valid), 0);
                check("busy_at_valid", 32'(rx_busy), 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 32'(rx_valid), 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rx_data", 32'(rx_data), 32'(e.d));
                    check("parity_err", 32'(parity_err), 32'(e.pe));
                    check("frame_err", 32'(frame_err), 32'(e.fe));
                    check("latency", cyc - e.cyc, LAT);
                end
            end
            prev_valid = rx_valid;
        end
    end

    task automatic wait_ticks(input int n);
        repeat (n) begin
            do @(posedge clk); while (!baud_tick);
        end
    endtask

    // Returns at the negedge right after a tick, the reference phase for every frame edge.
    task automatic align();
        wait_ticks(1);
        @(negedge clk);
    endtask

    task automatic idle(input int ticks);
        rx = 1'b1;
        if (ticks > 0) begin
            wait_ticks(ticks);
            @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop,
                              input int rst_bit);
        logic bits[$];
        exp_t e;
        bits.push_back(1'b0);
        for (int i = 0; i < DATA_BITS; i++) bits.push_back(d[i]);
`ifdef UART_RX_PARITY_EN
        bits.push_back(pbit);
        e.pe = (^d) ^ pbit;
`else
        e.pe = 1'b0;
`endif
        bits.push_back(stop);
        e.d   = d;
        e.fe  = ~stop;
        e.cyc = cyc;
        exp_q.push_back(e);
        for (int i = 0; i < bits.size(); i++) begin
            rx = bits[i];
            if (i == rst_bit) begin
                wait_ticks(OVERSAMPLE / 2);
                @(negedge clk);
                rst = 1'b1;
                rx  = 1'b1;
                void'(exp_q.pop_back());
                @(negedge clk);
                rst = 1'b0;
                check("mrst_valid", 32'(rx_valid), 0);
                check("mrst_busy", 32'(rx_busy), 0);
                check("mrst_data", 32'(rx_data), 0);
                check("mrst_perr", 32'(parity_err), 0);
                check("mrst_ferr", 32'(frame_err), 0);
                return;
            end
            wait_ticks(OVERSAMPLE);
            @(negedge clk);
            if (i == 1) check("busy_mid_frame", 32'(rx_busy), 1);
        end
    endtask

    initial begin
        int         busy_cnt;
        logic [7:0] d;
        logic       pbit;
        logic       stop;
        logic [7:0] last_d;

        rst = 1'b1;
        rx  = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        check("reset_data", 32'(rx_data), 0);
        check("reset_valid", 32'(rx_valid), 0);
        check("reset_busy", 32'(rx_busy), 0);
        check("reset_perr", 32'(parity_err), 0);
        check("reset_ferr", 32'(frame_err), 0);
        align();
        idle(4);

        send_frame(8'hA5, 1'b0, 1'b1, -1);
        idle(10);
        send_frame(8'hA5, 1'b1, 1'b1, -1);
        idle(10);
        send_frame(8'h3C, 1'b0, 1'b0, -1);
        idle(24);

        // 4-tick low glitch: start is rejected at mid-start, busy for exactly 8 ticks.
        busy_cnt = 0;
        rx = 1'b0;
        for (int i = 0; i < 24 * TICK_CLKS; i++) begin
            @(negedge clk);
            if (rx_busy) busy_cnt++;
            if (i == 4 * TICK_CLKS - 1) rx = 1'b1;
        end
        check("glitch_busy_clks", busy_cnt, (OVERSAMPLE / 2) * TICK_CLKS);
        check("glitch_busy_end", 32'(rx_busy), 0);
        align();

        send_frame(8'h00, 1'b0, 1'b1, -1);
        send_frame(8'hFF, 1'b0, 1'b1, -1);
        idle(10);

        send_frame(8'hC3, 1'b0, 1'b1, 5);
        idle(2 * OVERSAMPLE);
        align();
        send_frame(8'h5A, 1'b0, 1'b1, -1);
        idle(8);

        last_d = 8'h5A;
        for (int n = 0; n < 20; n++) begin
            d    = 8'($urandom_range(0, 255));
            pbit = (^d) ^ ($urandom_range(0, 9) < 3);
            stop = ($urandom_range(0, 19) >= 3);
            send_frame(d, pbit, stop, -1);
            last_d = d;
            if (!stop) idle(24);
            else       idle($urandom_range(0, 20));
        end

        idle(3 * OVERSAMPLE);
        check("missing_valid", exp_q.size(), 0);
        check("final_busy", 32'(rx_busy), 0);
        check("data_hold", 32'(rx_data), 32'(last_d));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
